// File: rtl/mandel_iter.sv
// Per-pixel Mandelbrot iteration engine: one z <= z^2 + c step per clock,
// reports the escape count through valid/ready handshakes on both sides.

// Combinational signed fixed-point multiply; result truncates toward -inf.
module fx_mul #(
  parameter int WIDTH = 32,
  parameter int SCALE = 25
) (
  input  logic signed [WIDTH:0] a,
  input  logic signed [WIDTH:0] b,
  output logic signed [WIDTH:0] p
);
  logic signed [2*WIDTH+1:0] full;

  assign full = a * b;
  assign p    = (WIDTH+1)'(full >>> SCALE);
endmodule

// state | meaning
// IDLE  | waiting for a point c (in_ready high once out of reset)
// ITER  | one escape test / z update per cycle
// DONE  | result presented, held until out_ready
module mandel_iter #(
  parameter int WIDTH  = 32,
  parameter int SCALE  = 25,
  parameter int ITER_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH:0]      c_re,
  input  logic [WIDTH:0]      c_im,
  input  logic [ITER_W-1:0]   max_iter,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ITER_W-1:0]   out_iter,
  output logic                out_escaped
);
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  localparam logic [WIDTH+1:0] THRESH = (WIDTH+2)'(1) << (SCALE + 2);

  state_t              state_q, state_d;
  logic signed [WIDTH:0] zr_q, zr_d, zi_q, zi_d;
  logic [WIDTH:0]      c_re_q, c_re_d, c_im_q, c_im_d;
  logic [ITER_W-1:0]   max_iter_q, max_iter_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [ITER_W-1:0]   out_iter_q, out_iter_d;
  logic                out_esc_q, out_esc_d;
  logic                live_q, live_d;

  logic signed [WIDTH:0]   zr2, zi2, zri;
  logic signed [WIDTH+1:0] mag;
  logic                    escape;

  fx_mul #(.WIDTH(WIDTH), .SCALE(SCALE)) u_mul_rr (.a(zr_q), .b(zr_q), .p(zr2));
  fx_mul #(.WIDTH(WIDTH), .SCALE(SCALE)) u_mul_ii (.a(zi_q), .b(zi_q), .p(zi2));
  fx_mul #(.WIDTH(WIDTH), .SCALE(SCALE)) u_mul_ri (.a(zr_q), .b(zi_q), .p(zri));

  // Sum is one bit wider than the products so it cannot wrap.
  assign mag    = {zr2[WIDTH], zr2} + {zi2[WIDTH], zi2};
  assign escape = mag > $signed(THRESH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      zr_q       <= '0;
      zi_q       <= '0;
      c_re_q     <= '0;
      c_im_q     <= '0;
      max_iter_q <= '0;
      iter_q     <= '0;
      out_iter_q <= '0;
      out_esc_q  <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      zr_q       <= zr_d;
      zi_q       <= zi_d;
      c_re_q     <= c_re_d;
      c_im_q     <= c_im_d;
      max_iter_q <= max_iter_d;
      iter_q     <= iter_d;
      out_iter_q <= out_iter_d;
      out_esc_q  <= out_esc_d;
      live_q     <= live_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    zr_d       = zr_q;
    zi_d       = zi_q;
    c_re_d     = c_re_q;
    c_im_d     = c_im_q;
    max_iter_d = max_iter_q;
    iter_d     = iter_q;
    out_iter_d = out_iter_q;
    out_esc_d  = out_esc_q;
    live_d     = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (in_valid && live_q) begin
          c_re_d     = c_re;
          c_im_d     = c_im;
          max_iter_d = max_iter;
          zr_d       = '0;
          zi_d       = '0;
          iter_d     = '0;
          state_d    = ITER;
        end
      end
      ITER: begin
        if (escape) begin
          out_esc_d  = 1'b1;
          out_iter_d = iter_q;
          state_d    = DONE;
        end else if (iter_q == max_iter_q) begin
          out_esc_d  = 1'b0;
          out_iter_d = iter_q;
          state_d    = DONE;
        end else begin
          zr_d   = zr2 - zi2 + $signed(c_re_q);
          zi_d   = (zri <<< 1) + $signed(c_im_q);
          iter_d = iter_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // live_q keeps in_ready low during reset and for no longer than one clock after.
  assign in_ready    = (state_q == IDLE) && live_q;
  assign out_valid   = (state_q == DONE);
  assign out_iter    = out_iter_q;
  assign out_escaped = out_esc_q;
endmodule
